// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared sizing, types and helpers for the time-multiplexed 8-band equalizer.
// The sizing constants here are the single source of truth for the sequencer
// and its MAC unit.
// ---------------------------------------------------------------------------
package eq_pkg;

    localparam int NUM_BANDS = 8;   // equalizer bands
    localparam int NUM_TAPS  = 15;  // FIR taps per band (symmetric, stored in full)
    localparam int DATA_W    = 16;  // signed sample width
    localparam int COEF_W    = 16;  // signed Q1.15 coefficient width
    localparam int GAIN_W    = 8;   // signed Q4.4 gain width (16 = unity)
    localparam int ACC_W     = 40;  // signed accumulator width
    localparam int ADDR_W    = 7;   // coefficient ROM address width

    localparam int COEF_FRAC = COEF_W - 1;  // fractional bits of Q1.15
    localparam int GAIN_FRAC = 4;           // fractional bits of Q4.4

    // Clocks from the accepting edge to the edge that raises out_valid.
    localparam int LATENCY = 2 + NUM_BANDS * (NUM_TAPS + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        GAIN,
        OUT
    } state_e;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [GAIN_W-1:0] gain_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam acc_t SAT_MAX = acc_t'((1 << (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(1 << (DATA_W - 1)));

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic sample_t sat16(input acc_t v);
        sample_t r;
        if (v > SAT_MAX) begin
            r = sample_t'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            r = sample_t'(SAT_MIN);
        end else begin
            r = sample_t'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/eq_mac.sv
// ---------------------------------------------------------------------------
// eq_mac
// Shared signed multiply-accumulate unit. One product per enabled cycle is
// sign-extended and added into the accumulator; clr_i wins over en_i.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr_i       clear accumulator on the next edge
//   en_i        add a_i*b_i on the next edge
//   a_i, b_i    signed operands
//   acc_o       signed accumulator
// ---------------------------------------------------------------------------
module eq_mac
    import eq_pkg::*;
#(
    parameter int A_W   = DATA_W,
    parameter int B_W   = COEF_W,
    parameter int OUT_W = ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] acc_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [OUT_W-1:0] prod_ext;
    logic signed [OUT_W-1:0] acc_d;
    logic signed [OUT_W-1:0] acc_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        prod     = a_i * b_i;
        prod_ext = {{(OUT_W - P_W){prod[P_W-1]}}, prod};
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/eq_band_sequencer.sv
// ---------------------------------------------------------------------------
// eq_band_sequencer
// Time-multiplexed controller for the 8-band equalizer. Accepts one sample,
// shifts it into the tap delay line, then walks every band: streams the band's
// coefficients from an external 1-cycle-latency ROM through the shared MAC,
// scales the band result by its gain and adds it to the running total. The
// total is rescaled, saturated to 16 bits and presented with a valid/ready
// handshake.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     x_in valid
//   in_ready     high only while idle
//   x_in         signed input sample
//   gain_flat    band b gain (Q4.4) in bits [b*GAIN_W +: GAIN_W]
//   coef_rd_en   coefficient ROM read strobe
//   coef_addr    band*NUM_TAPS + tap
//   coef_in      ROM data, valid one cycle after coef_rd_en
//   out_valid    y_out valid
//   out_ready    sink accepts y_out
//   y_out        saturated signed output sample
// ---------------------------------------------------------------------------
module eq_band_sequencer
    import eq_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      x_in,
    input  logic [NUM_BANDS*GAIN_W-1:0]   gain_flat,
    output logic                          coef_rd_en,
    output logic [ADDR_W-1:0]             coef_addr,
    input  logic signed [COEF_W-1:0]      coef_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      y_out
);

    localparam int BAND_W = $clog2(NUM_BANDS + 1);
    localparam int TAP_W  = $clog2(NUM_TAPS + 1);

    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0] BAND_END  = BAND_W'(NUM_BANDS);
    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_TAPS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [BAND_W-1:0] band_q, band_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    acc_t              total_q, total_d;
    sample_t           y_out_q, y_out_d;
    sample_t           dline_q [NUM_TAPS];   // dline_q[k] = x[n-k]
    gain_t             gain_q  [NUM_BANDS];  // gains frozen for the current sample

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic    accept;      // input handshake completes on this edge
    logic    snap;        // capture gain_flat on this edge
    logic    mac_clr;
    logic    mac_en;
    sample_t mac_a;
    acc_t    mac_acc;
    gain_t   gain_sel;
    acc_t    gain_ext;
    acc_t    band_term;

    eq_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .OUT_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (coef_in),
        .acc_o (mac_acc)
    );

    // Accumulate cycle t pairs coef[t-1] (arriving now from the ROM) with
    // delay-line entry t-1, so the operand lags the tap counter by one.
    always_comb begin
        mac_a = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (int'(tap_q) == k + 1) begin
                mac_a = dline_q[k];
            end
        end
    end

    // Band contribution: drop the Q1.15 coefficient fraction, then apply the
    // Q4.4 gain. The Q4.4 fraction is removed once, on the final total.
    always_comb begin
        gain_sel = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (int'(band_q) == b) begin
                gain_sel = gain_q[b];
            end
        end
        gain_ext  = {{(ACC_W - GAIN_W){gain_sel[GAIN_W-1]}}, gain_sel};
        band_term = (mac_acc >>> COEF_FRAC) * gain_ext;
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        band_d     = band_q;
        tap_d      = tap_q;
        total_d    = total_q;
        y_out_d    = y_out_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        coef_rd_en = 1'b0;
        coef_addr  = '0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        accept     = 1'b0;
        snap       = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                snap    = 1'b1;
                total_d = '0;
                band_d  = '0;
                tap_d   = '0;
                mac_clr = 1'b1;
                state_d = MAC;
            end

            MAC: begin
                if (tap_q < LAST_TAP) begin
                    coef_rd_en = 1'b1;
                    coef_addr  = ADDR_W'(int'(band_q) * NUM_TAPS + int'(tap_q));
                end
                if (tap_q != '0) begin
                    mac_en = 1'b1;
                end
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = GAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end

            GAIN: begin
                if (band_q != BAND_END) begin
                    total_d = total_q + band_term;
                    mac_clr = 1'b1;
                    band_d  = band_q + 1'b1;
                    // After the last band, one more GAIN pass (band == BAND_END)
                    // saturates the registered total into y_out.
                    state_d = (band_q == LAST_BAND) ? GAIN : MAC;
                end else begin
                    y_out_d = sat16(total_q >>> GAIN_FRAC);
                    state_d = OUT;
                end
            end

            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            band_q  <= '0;
            tap_q   <= '0;
            total_q <= '0;
            y_out_q <= '0;
            // NOTE: the delay line and gain snapshot are storage arrays, but
            // they are cleared on reset so an aborted or earlier sample can
            // never leak into the first outputs after reset.
            for (int k = 0; k < NUM_TAPS; k++) begin
                dline_q[k] <= '0;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            tap_q   <= tap_d;
            total_q <= total_d;
            y_out_q <= y_out_d;
            // The sample is taken on its handshake edge, while x_in is valid.
            if (accept) begin
                dline_q[0] <= x_in;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    dline_q[k] <= dline_q[k-1];
                end
            end
            if (snap) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    gain_q[b] <= gain_flat[b*GAIN_W +: GAIN_W];
                end
            end
        end
    end

    assign y_out = y_out_q;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eq_band_sequencer
// Self-checking bench for eq_band_sequencer: a registered coefficient ROM
// model, a behavioural equalizer model working on a sample history queue,
// a table of hand-derived vectors, hand-written corner sequences and a
// randomized run.
// ---------------------------------------------------------------------------
module tb_eq_band_sequencer;
    import eq_pkg::*;

    logic                        clk       = 1'b0;
    logic                        rst_n     = 1'b0;
    logic                        in_valid  = 1'b0;
    logic                        out_ready = 1'b1;
    logic signed [DATA_W-1:0]    x_in      = '0;
    logic [NUM_BANDS*GAIN_W-1:0] gain_flat = '0;
    logic signed [COEF_W-1:0]    coef_in   = '0;
    logic                        in_ready;
    logic                        coef_rd_en;
    logic [ADDR_W-1:0]           coef_addr;
    logic                        out_valid;
    logic signed [DATA_W-1:0]    y_out;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int rom  [128];
    int hits [128];
    int reads = 0;
    int hist [$];   // accepted samples, newest first

    always #5 clk = ~clk;

    eq_band_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .gain_flat  (gain_flat),
        .coef_rd_en (coef_rd_en),
        .coef_addr  (coef_addr),
        .coef_in    (coef_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out)
    );

    // Coefficient ROM: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (coef_rd_en) coef_in <= COEF_W'(rom[coef_addr]);
    end

    task automatic check(input string name, input longint got, input longint want);
        total_cnt++;
        if (got != want) begin
            bad_cnt++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Advance one clock and sample just after the edge; also log the ROM read
    // that the DUT is requesting for the coming edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (coef_rd_en === 1'b1) begin
            hits[coef_addr]++;
            reads++;
        end
    endtask

    // Equalizer reference: per band FIR over the history, floor-shift by 15,
    // times gain, sum, floor-shift by 4, clamp.
    function automatic longint model_y(input logic [NUM_BANDS*GAIN_W-1:0] g);
        longint total;
        longint acc;
        total = 0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            acc = 0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (k < hist.size()) acc += longint'(hist[k]) * longint'(rom[b*NUM_TAPS + k]);
            end
            total += (acc >>> 15) * longint'($signed(g[b*GAIN_W +: GAIN_W]));
        end
        total = total >>> 4;
        if (total > 32767) total = 32767;
        if (total < -32768) total = -32768;
        return total;
    endfunction

    function automatic logic [NUM_BANDS*GAIN_W-1:0] flat_gains(input int g);
        logic [NUM_BANDS*GAIN_W-1:0] r;
        for (int b = 0; b < NUM_BANDS; b++) r[b*GAIN_W +: GAIN_W] = GAIN_W'(g);
        return r;
    endfunction

    function automatic logic [NUM_BANDS*GAIN_W-1:0] rand_gains();
        logic [NUM_BANDS*GAIN_W-1:0] r;
        for (int b = 0; b < NUM_BANDS; b++)
            r[b*GAIN_W +: GAIN_W] = GAIN_W'(int'($urandom_range(0, 64)) - 32);
        return r;
    endfunction

    task automatic set_rom(input int mode);
        for (int a = 0; a < 128; a++) rom[a] = 0;
        case (mode)
            0: rom[0] = 32767;
            1: rom[2] = 16384;
            2: for (int b = 0; b < NUM_BANDS; b++) rom[b*NUM_TAPS] = 32767;
            default: for (int a = 0; a < 128; a++) rom[a] = int'($urandom_range(0, 4095)) - 2048;
        endcase
    endtask

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
        hist.delete();
        tick();
    endtask

    // Wait for in_ready, hand over one sample, wait for the result, hold it
    // under backpressure for 'hold' cycles, then complete the handshake.
    task automatic run_sample(input int x, input logic [NUM_BANDS*GAIN_W-1:0] g,
                              input int hold, input int chg_at,
                              input logic [NUM_BANDS*GAIN_W-1:0] g_alt,
                              output longint y);
        longint want;
        int     guard;
        int     lat;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        x_in      = DATA_W'(x);
        gain_flat = g;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        check("in_ready_seen", in_ready, 1);
        tick();  // accepting edge
        in_valid = 1'b0;
        hist.push_front(x);
        if (hist.size() > NUM_TAPS) void'(hist.pop_back());
        want = model_y(g);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            tick();
            lat++;
            if (lat == chg_at) gain_flat = g_alt;
        end
        check("latency", lat, LATENCY);
        y = y_out;
        check("y_model", y, want);
        check("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_y", y_out, y);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    typedef struct {
        string name;
        int    rom_mode;
        bit    do_rst;
        int    x;
        int    gain;
        int    want;
    } vec_t;

    vec_t   vecs [6];
    longint y;
    int     once;
    int     guard;

    initial begin
        vecs[0] = '{"impulse_b0",   0, 1'b1,  16384,  16,  16383};
        vecs[1] = '{"delay_x1000",  1, 1'b1,   1000,  16,      0};
        vecs[2] = '{"delay_x0_a",   1, 1'b0,      0,  16,      0};
        vecs[3] = '{"delay_x0_b",   1, 1'b0,      0,  16,    500};
        vecs[4] = '{"sat_pos",      2, 1'b1,  30000, 127,  32767};
        vecs[5] = '{"sat_neg",      2, 1'b0, -30000, 127, -32768};

        // Reset behaviour: outputs at rest during and right after reset.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_y_out", y_out, 0);
            check("rst_coef_rd_en", coef_rd_en, 0);
            check("rst_coef_addr", coef_addr, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_y_out", y_out, 0);
        check("post_rst_coef_rd_en", coef_rd_en, 0);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            set_rom(vecs[i].rom_mode);
            if (vecs[i].do_rst) do_reset(2);
            if (i == 0) begin
                for (int a = 0; a < 128; a++) hits[a] = 0;
                reads = 0;
            end
            run_sample(vecs[i].x, flat_gains(vecs[i].gain), 0, -1, '0, y);
            check(vecs[i].name, y, vecs[i].want);
            if (i == 0) begin
                once = 0;
                for (int a = 0; a < NUM_BANDS*NUM_TAPS; a++) if (hits[a] == 1) once++;
                check("addr_reads", reads, NUM_BANDS*NUM_TAPS);
                check("addr_sweep_once", once, NUM_BANDS*NUM_TAPS);
            end
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        set_rom(3);
        run_sample(12345, rand_gains(), 10, -1, '0, y);

        // Gain changed 50 cycles after accept: old gains must still apply.
        set_rom(3);
        run_sample(-9876, rand_gains(), 0, 50, rand_gains(), y);

        // Mid-operation reset, then a fresh delay line.
        set_rom(1);
        do_reset(2);
        run_sample(7000, flat_gains(16), 0, -1, '0, y);
        in_valid  = 1'b1;
        x_in      = DATA_W'(8000);
        gain_flat = flat_gains(16);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        tick();  // accepting edge of the sample to be aborted
        in_valid = 1'b0;
        repeat (60) tick();
        rst_n = 1'b0;
        tick();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_coef_rd_en", coef_rd_en, 0);
        check("abort_y_out", y_out, 0);
        rst_n = 1'b1;
        hist.delete();
        tick();
        run_sample(100, flat_gains(16), 0, -1, '0, y);
        check("fresh_line_1", y, 0);
        run_sample(200, flat_gains(16), 0, -1, '0, y);
        run_sample(300, flat_gains(16), 0, -1, '0, y);
        check("fresh_line_3", y, 50);

        // Randomized samples against the model.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) set_rom(3);
            run_sample(int'($urandom_range(0, 65535)) - 32768, rand_gains(),
                       int'($urandom_range(0, 3)), -1, '0, y);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/eq_band_sequencer.md
Name: eq_band_sequencer

Overview:
Time-multiplexed controller for the 8-band equalizer. It shares one multiply-accumulate (MAC) unit across all bands and taps, and owns the input sample delay line. It sequences coefficient ROM reads, applies per-band gains, and sums the bands into a saturated 16-bit output. It sits between the sample source and the output sink, and replaces the parallel filter/gain/adder tree.

Parameters:
NUM_BANDS, 8, number of equalizer bands
NUM_TAPS, 15, FIR taps per band (symmetric coefficients, stored in full)
DATA_W, 16, sample width (signed)
COEF_W, 16, coefficient width (signed Q1.15)
GAIN_W, 8, gain width (signed Q4.4, 16 = unity)
ACC_W, 40, accumulator width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  x_in valid
in_ready  out  1  block accepts sample
x_in  in  DATA_W  input sample, signed
gain_flat  in  NUM_BANDS*GAIN_W  band b gain in bits [b*GAIN_W +: GAIN_W]
coef_rd_en  out  1  coefficient ROM read strobe
coef_addr  out  7  ROM address = band*NUM_TAPS + tap
coef_in  in  COEF_W  ROM data, valid 1 cycle after coef_rd_en
out_valid  out  1  y_out valid
out_ready  in  1  sink accepts y_out
y_out  out  DATA_W  equalized sample, signed, saturated

Behaviour:
- One clock (clk). Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block.
- Reset values:
  - in_ready=1, out_valid=0, y_out=0, coef_rd_en=0, coef_addr=0.
  - Delay line, accumulators and gain snapshot cleared to 0.
  - State IDLE.
- FSM states: IDLE, LOAD, MAC, GAIN, OUT.
- IDLE:
  - in_ready=1 only in this state.
  - in_valid&in_ready -> LOAD.
- LOAD (1 cycle):
  - Shift x_in into delay line: d[0]=newest, d[k]=x[n-k].
  - Snapshot gain_flat.
  - Clear total; band=0 -> MAC.
- MAC (NUM_TAPS+1 cycles per band):
  - Issue cycles t=0..NUM_TAPS-1: coef_rd_en=1, coef_addr=band*NUM_TAPS+t.
  - Accumulate cycles t=1..NUM_TAPS: acc += d[t-1]*coef_in (32-bit signed product, sign-extended to ACC_W).
  - acc is cleared at band start.
  - After the last accumulate -> GAIN.
- GAIN (1 cycle):
  - total += (acc >>> 15) * gain[band], arithmetic shift, signed.
  - band<NUM_BANDS-1: band++ -> MAC.
  - Otherwise: y_out=sat16(total >>> 4) -> OUT.
- OUT:
  - out_valid=1; y_out held stable until out_ready.
  - out_valid&out_ready -> IDLE next edge, with out_valid=0.
  - in_ready stays 0 until IDLE.
- Latency: out_valid rises exactly LATENCY = 2 + NUM_BANDS*(NUM_TAPS+2) = 138 clocks after the accepting edge. Minimum sample period is 140 clocks.
- Saturation: >32767 -> 32767; < -32768 -> -32768. No wrap anywhere in total (ACC_W headroom).
- gain_flat changes after LOAD do not affect the current sample.
- in_valid while busy is ignored; the sample is not consumed.
- Reset mid-operation: abort; all reset values apply on the next edge; any partial result is discarded.
- Coefficient ROM is external, read-only, with fixed 1-cycle read latency.

Decomposition:
- Package eq_pkg holds:
  - parameter defaults;
  - LATENCY constant;
  - state enum typedef (IDLE, LOAD, MAC, GAIN, OUT);
  - signed sample/coef/gain/acc typedefs;
  - sat16 function.
- Sub-module eq_mac: signed multiply with clear/enable accumulate, ACC_W output. The FSM, delay line and gain stage stay in eq_band_sequencer.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, y_out=0, coef_rd_en=0 throughout reset and on the first cycle after.
- Impulse through band 0: ROM all 0 except addr 0=32767; all gains 16; x=16384 -> out_valid at accept+138, y_out=16383; coef_addr sweeps 0..119 exactly once.
- Delay line: ROM all 0 except addr 2=16384; gains 16; inputs 1000, 0, 0 -> outputs 0, 0, 500.
- Saturation: ROM addr b*15 = 32767 for b=0..7; gains 127. x=30000 -> y_out=32767. x=-30000 -> y_out=-32768.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y_out and out_valid stable, in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Gain snapshot and mid-op reset:
  - Change gain_flat 50 cycles after accept -> result matches the old gains.
  - Assert rst_n=0 at cycle 60 of a new sample -> next edge gives IDLE, in_ready=1.
  - Next impulse test output matches a fresh delay line (no stale samples).
